// File: rtl/axis_video_rx_checker.sv
// ---------------------------------------------------------------------------
// axis_video_rx_checker
//
// AXI4-Stream video sink. Accepts pixels from a video stream source
// (tuser = start of frame, tlast = end of line), tracks the x/y position of
// every accepted pixel and checks line/frame framing against
// H_ACTIVE x V_ACTIVE. Reports per-beat framing errors, frame completion,
// clean-frame and error counters and a lock flag.
//
// Optional feature macro: BACKPRESSURE_EN
//   defined   : s_tready follows an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5)
//               so that the source is exercised with random stalls.
//   undefined : s_tready is 1 from the first clock edge after reset.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   s_tdata/s_tvalid/s_tready/s_tuser/s_tlast   AXI4-Stream sink
//   o_pixel, o_pixel_valid, o_x, o_y            last accepted pixel + position
//   o_frame_done                                pulse on final beat of a frame
//   o_err_sof, o_err_early_eol, o_err_late_eol  framing error pulses
//   o_frame_count                               clean frames (wraps)
//   o_err_count                                 error pulses (saturates)
//   o_locked                                    last completed frame was clean
// ---------------------------------------------------------------------------
module axis_video_rx_checker #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int DATA_W   = 24,
    parameter int X_W      = 11,
    parameter int Y_W      = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tuser,
    input  logic              s_tlast,
    output logic [DATA_W-1:0] o_pixel,
    output logic              o_pixel_valid,
    output logic [X_W-1:0]    o_x,
    output logic [Y_W-1:0]    o_y,
    output logic              o_frame_done,
    output logic              o_err_sof,
    output logic              o_err_early_eol,
    output logic              o_err_late_eol,
    output logic [15:0]       o_frame_count,
    output logic [15:0]       o_err_count,
    output logic              o_locked
);

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        RECV     = 1'b1
    } state_t;

    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);
    localparam logic [X_W-1:0] X_ONE  = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);

    // Saturating 16-bit increment used by the error counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

    state_t          state_r;
    logic            tready_r;
    logic [X_W-1:0]  col_r;        // column of the next expected pixel
    logic [Y_W-1:0]  row_r;        // row of the next expected pixel
    logic            frame_err_r;  // current frame has seen an error

    logic            beat_s;
    logic            sof_beat_s;
    logic            pix_beat_s;
    logic [X_W-1:0]  cur_col_s;
    logic [Y_W-1:0]  cur_row_s;
    logic            last_col_s;
    logic            last_row_s;
    logic            err_sof_s;
    logic            err_early_s;
    logic            err_late_s;
    logic            err_any_s;
    logic            close_s;
    logic            end_frame_s;
    logic            ferr_next_s;

    assign s_tready = tready_r;

`ifdef BACKPRESSURE_EN
    logic [7:0] lfsr_r;

    // Fibonacci LFSR step for x^8+x^6+x^5+x^4+1 (left shift).
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        lfsr_next = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Free-running stall pattern generator, restarted from the seed on reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr_r <= 8'hA5;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end
`endif

    // Per-beat framing decisions. A tuser beat is always pixel (0,0), so the
    // position used for the checks is forced to the origin on that beat.
    always_comb begin
        beat_s     = s_tvalid & tready_r;
        sof_beat_s = beat_s & s_tuser;
        pix_beat_s = beat_s & (s_tuser | (state_r == RECV));
        if (s_tuser) begin
            cur_col_s = {X_W{1'b0}};
            cur_row_s = {Y_W{1'b0}};
        end else begin
            cur_col_s = col_r;
            cur_row_s = row_r;
        end
        last_col_s  = (cur_col_s == X_LAST);
        last_row_s  = (cur_row_s == Y_LAST);
        // Only one error per beat: a restart masks any line-length error.
        err_sof_s   = sof_beat_s & (state_r == RECV);
        err_early_s = pix_beat_s & ~err_sof_s & s_tlast & ~last_col_s;
        err_late_s  = pix_beat_s & ~err_sof_s & ~s_tlast & last_col_s;
        err_any_s   = err_sof_s | err_early_s | err_late_s;
        // A late EOL still closes the line so the source can resynchronise.
        close_s     = pix_beat_s & (s_tlast | last_col_s);
        end_frame_s = close_s & last_row_s;
        if (sof_beat_s) begin
            ferr_next_s = err_any_s;
        end else begin
            ferr_next_s = frame_err_r | err_any_s;
        end
    end

    // Receive FSM, position counters, registered outputs and statistics.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r         <= WAIT_SOF;
            tready_r        <= 1'b0;
            col_r           <= {X_W{1'b0}};
            row_r           <= {Y_W{1'b0}};
            frame_err_r     <= 1'b0;
            o_pixel         <= {DATA_W{1'b0}};
            o_pixel_valid   <= 1'b0;
            o_x             <= {X_W{1'b0}};
            o_y             <= {Y_W{1'b0}};
            o_frame_done    <= 1'b0;
            o_err_sof       <= 1'b0;
            o_err_early_eol <= 1'b0;
            o_err_late_eol  <= 1'b0;
            o_frame_count   <= 16'd0;
            o_err_count     <= 16'd0;
            o_locked        <= 1'b0;
        end else begin
`ifdef BACKPRESSURE_EN
            tready_r <= (lfsr_r[1:0] != 2'b00);
`else
            tready_r <= 1'b1;
`endif
            o_pixel_valid   <= pix_beat_s;
            o_frame_done    <= end_frame_s;
            o_err_sof       <= err_sof_s;
            o_err_early_eol <= err_early_s;
            o_err_late_eol  <= err_late_s;

            if (pix_beat_s) begin
                o_pixel     <= s_tdata;
                o_x         <= cur_col_s;
                o_y         <= cur_row_s;
                frame_err_r <= ferr_next_s;
                if (close_s) begin
                    col_r <= {X_W{1'b0}};
                    if (last_row_s) begin
                        row_r   <= {Y_W{1'b0}};
                        state_r <= WAIT_SOF;
                    end else begin
                        row_r   <= cur_row_s + Y_ONE;
                        state_r <= RECV;
                    end
                end else begin
                    col_r   <= cur_col_s + X_ONE;
                    row_r   <= cur_row_s;
                    state_r <= RECV;
                end
            end else begin
                // Non-beat cycles and pre-SOF drops leave position untouched.
                state_r <= state_r;
            end

            if (err_any_s) begin
                o_err_count <= sat_inc16(o_err_count);
            end else begin
                o_err_count <= o_err_count;
            end

            if (end_frame_s && !ferr_next_s) begin
                o_frame_count <= o_frame_count + 16'd1;
            end else begin
                o_frame_count <= o_frame_count;
            end

            if (err_any_s) begin
                o_locked <= 1'b0;
            end else if (end_frame_s) begin
                o_locked <= ~ferr_next_s;
            end else begin
                o_locked <= o_locked;
            end
        end
    end

endmodule

// File: tb/tb_axis_video_rx_checker.sv
module tb_axis_video_rx_checker;

    localparam int H = 8;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [23:0] s_tdata = 24'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tuser = 1'b0;
    logic        s_tlast = 1'b0;
    logic [23:0] o_pixel;
    logic        o_pixel_valid;
    logic [10:0] o_x;
    logic [9:0]  o_y;
    logic        o_frame_done;
    logic        o_err_sof;
    logic        o_err_early_eol;
    logic        o_err_late_eol;
    logic [15:0] o_frame_count;
    logic [15:0] o_err_count;
    logic        o_locked;

    int n_pass = 0;
    int n_total = 0;

    axis_video_rx_checker #(
        .H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(24), .X_W(11), .Y_W(10)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tuser(s_tuser), .s_tlast(s_tlast),
        .o_pixel(o_pixel), .o_pixel_valid(o_pixel_valid),
        .o_x(o_x), .o_y(o_y), .o_frame_done(o_frame_done),
        .o_err_sof(o_err_sof), .o_err_early_eol(o_err_early_eol),
        .o_err_late_eol(o_err_late_eol), .o_frame_count(o_frame_count),
        .o_err_count(o_err_count), .o_locked(o_locked)
    );

    always #5 clk = ~clk;

    // Reference model: stream position and expected outputs, written from
    // the framing rules (position of next pixel, error priority, counters).
    bit          m_in;
    int          m_col, m_row;
    bit          m_ferr;
    bit          m_pv, m_esof, m_eearly, m_elate, m_done, m_locked;
    int          m_x, m_y;
    logic [23:0] m_pix;
    logic [15:0] m_fc, m_ec;

    task automatic model_reset();
        m_in = 0; m_col = 0; m_row = 0; m_ferr = 0;
        m_pv = 0; m_esof = 0; m_eearly = 0; m_elate = 0; m_done = 0;
        m_locked = 0; m_x = 0; m_y = 0; m_pix = 24'd0; m_fc = 16'd0; m_ec = 16'd0;
    endtask

    task automatic model_idle();
        m_pv = 0; m_esof = 0; m_eearly = 0; m_elate = 0; m_done = 0;
    endtask

    task automatic model_beat(input bit u, input bit l, input logic [23:0] d);
        bit err;
        model_idle();
        if (!m_in && !u) return;
        if (u) begin
            m_esof = m_in;
            m_col = 0; m_row = 0; m_ferr = 0; m_in = 1;
        end
        m_pv = 1; m_pix = d; m_x = m_col; m_y = m_row;
        if (!m_esof) begin
            if (l && m_col < H - 1) m_eearly = 1;
            else if (!l && m_col == H - 1) m_elate = 1;
        end
        err = m_esof | m_eearly | m_elate;
        if (err) begin
            m_ferr = 1; m_locked = 0;
            if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
        end
        if (l || m_col == H - 1) begin
            m_col = 0;
            if (m_row == V - 1) begin
                m_row = 0; m_in = 0; m_done = 1;
                if (!m_ferr) begin m_fc = m_fc + 16'd1; m_locked = 1; end
                else m_locked = 0;
            end else begin
                m_row = m_row + 1;
            end
        end else begin
            m_col = m_col + 1;
        end
    endtask

    // Present one beat and hold it until the sink accepts it.
    task automatic drive_beat(input bit u, input bit l, input logic [23:0] d);
        bit rdy;
        int budget;
        @(negedge clk);
        s_tvalid = 1'b1; s_tuser = u; s_tlast = l; s_tdata = d;
        rdy = 0;
        budget = 0;
        while (budget < 64) begin
            rdy = s_tready;
            @(posedge clk);
            budget++;
            if (rdy) break;
            @(negedge clk);
        end
        #1;
        n_total++;
        if (!rdy) $display("FAIL handshake_timeout got ready=0 required ready=1");
        else begin n_pass++; model_beat(u, l, d); end
    endtask

    // One cycle with no beat; sideband lines carry junk that must be ignored.
    task automatic idle_cycle();
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tuser = 1'($urandom_range(0, 1));
        s_tlast = 1'($urandom_range(0, 1));
        s_tdata = 24'($urandom);
        @(posedge clk);
        #1;
        model_idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; s_tvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic send_frame();
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                drive_beat(r == 0 && c == 0, c == H - 1, 24'($urandom));
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0; s_tvalid = 1'b1; s_tuser = 1'b1; s_tlast = 1'b1;
        @(posedge clk); #1;
        n_total++; if (s_tready !== 1'b0) $display("FAIL reset_tready got %0b required 0", s_tready); else n_pass++;
        n_total++; if (o_pixel_valid !== 1'b0) $display("FAIL reset_pv got %0b required 0", o_pixel_valid); else n_pass++;
        n_total++; if (o_frame_count !== 16'd0 || o_err_count !== 16'd0 || o_locked !== 1'b0)
            $display("FAIL reset_counters got fc=%0d ec=%0d lk=%0b required 0/0/0", o_frame_count, o_err_count, o_locked);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1; s_tvalid = 1'b0;
        model_reset();
        @(posedge clk); #1;
        n_total++; if (s_tready !== 1'b1) $display("FAIL reset_release_tready got %0b required 1", s_tready); else n_pass++;
    endtask

    task automatic test_clean_frames();
        int dones;
        do_reset();
        dones = 0;
        for (int f = 0; f < 3; f++)
            for (int r = 0; r < V; r++)
                for (int c = 0; c < H; c++) begin
                    drive_beat(r == 0 && c == 0, c == H - 1, 24'($urandom));
                    if (o_frame_done === 1'b1) dones++;
                end
        n_total++; if (dones != 3) $display("FAIL clean_done_pulses got %0d required 3", dones); else n_pass++;
        n_total++; if (o_frame_count !== 16'd3) $display("FAIL clean_fc got %0d required 3", o_frame_count); else n_pass++;
        n_total++; if (o_err_count !== 16'd0) $display("FAIL clean_ec got %0d required 0", o_err_count); else n_pass++;
        n_total++; if (o_locked !== 1'b1) $display("FAIL clean_locked got %0b required 1", o_locked); else n_pass++;
        n_total++; if (o_x !== 11'd7 || o_y !== 10'd3) $display("FAIL clean_last_xy got %0d/%0d required 7/3", o_x, o_y); else n_pass++;
        idle_cycle();
        n_total++; if (o_frame_done !== 1'b0) $display("FAIL clean_done_width got %0b required 0", o_frame_done); else n_pass++;
    endtask

    task automatic test_drop_before_sof();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_beat(1'b0, 1'($urandom_range(0, 1)), 24'($urandom));
            n_total++;
            if (o_pixel_valid !== 1'b0 || o_err_early_eol !== 1'b0 || o_err_late_eol !== 1'b0 || o_err_sof !== 1'b0)
                $display("FAIL drop_beat%0d got pv=%0b errs=%0b%0b%0b required 0", i, o_pixel_valid, o_err_sof, o_err_early_eol, o_err_late_eol);
            else n_pass++;
        end
        send_frame();
        n_total++; if (o_frame_done !== 1'b1) $display("FAIL drop_done got %0b required 1", o_frame_done); else n_pass++;
        n_total++; if (o_frame_count !== 16'd1) $display("FAIL drop_fc got %0d required 1", o_frame_count); else n_pass++;
    endtask

    task automatic test_early_eol();
        do_reset();
        for (int c = 0; c < H; c++) drive_beat(c == 0, c == H - 1, 24'($urandom));
        for (int c = 0; c < 5; c++) drive_beat(1'b0, c == 4, 24'($urandom));
        n_total++; if (o_err_early_eol !== 1'b1 || o_x !== 11'd4 || o_y !== 10'd1)
            $display("FAIL early_pulse got err=%0b x=%0d y=%0d required 1/4/1", o_err_early_eol, o_x, o_y);
        else n_pass++;
        drive_beat(1'b0, 1'b0, 24'h123456);
        n_total++; if (o_err_early_eol !== 1'b0 || o_x !== 11'd0 || o_y !== 10'd2 || o_pixel !== 24'h123456)
            $display("FAIL early_next got err=%0b x=%0d y=%0d pix=%0h required 0/0/2/123456", o_err_early_eol, o_x, o_y, o_pixel);
        else n_pass++;
        for (int c = 1; c < H; c++) drive_beat(1'b0, c == H - 1, 24'($urandom));
        for (int c = 0; c < H; c++) drive_beat(1'b0, c == H - 1, 24'($urandom));
        n_total++; if (o_frame_done !== 1'b1) $display("FAIL early_done got %0b required 1", o_frame_done); else n_pass++;
        n_total++; if (o_frame_count !== 16'd0 || o_locked !== 1'b0 || o_err_count !== 16'd1)
            $display("FAIL early_stats got fc=%0d lk=%0b ec=%0d required 0/0/1", o_frame_count, o_locked, o_err_count);
        else n_pass++;
    endtask

    task automatic test_late_eol();
        do_reset();
        for (int c = 0; c < H; c++) drive_beat(c == 0, 1'b0, 24'($urandom));
        n_total++; if (o_err_late_eol !== 1'b1 || o_x !== 11'd7 || o_y !== 10'd0)
            $display("FAIL late_pulse got err=%0b x=%0d y=%0d required 1/7/0", o_err_late_eol, o_x, o_y);
        else n_pass++;
        drive_beat(1'b0, 1'b0, 24'($urandom));
        n_total++; if (o_err_late_eol !== 1'b0 || o_x !== 11'd0 || o_y !== 10'd1)
            $display("FAIL late_next got err=%0b x=%0d y=%0d required 0/0/1", o_err_late_eol, o_x, o_y);
        else n_pass++;
        n_total++; if (o_err_count !== 16'd1) $display("FAIL late_ec got %0d required 1", o_err_count); else n_pass++;
    endtask

    task automatic test_mid_sof();
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < H; c++) drive_beat(r == 0 && c == 0, c == H - 1, 24'($urandom));
        for (int c = 0; c < 3; c++) drive_beat(1'b0, 1'b0, 24'($urandom));
        drive_beat(1'b1, 1'b0, 24'hABCDEF);
        n_total++; if (o_err_sof !== 1'b1 || o_x !== 11'd0 || o_y !== 10'd0 || o_pixel !== 24'hABCDEF)
            $display("FAIL sof_pulse got err=%0b x=%0d y=%0d pix=%0h required 1/0/0/abcdef", o_err_sof, o_x, o_y, o_pixel);
        else n_pass++;
        // Finish the restarted frame; it carries the restart error.
        for (int r = 0; r < V; r++)
            for (int c = (r == 0) ? 1 : 0; c < H; c++) drive_beat(1'b0, c == H - 1, 24'($urandom));
        n_total++; if (o_frame_done !== 1'b1 || o_frame_count !== 16'd0 || o_locked !== 1'b0)
            $display("FAIL sof_restart_frame got done=%0b fc=%0d lk=%0b required 1/0/0", o_frame_done, o_frame_count, o_locked);
        else n_pass++;
        send_frame();
        n_total++; if (o_frame_count !== 16'd1 || o_locked !== 1'b1 || o_err_count !== 16'd1)
            $display("FAIL sof_clean_after got fc=%0d lk=%0b ec=%0d required 1/1/1", o_frame_count, o_locked, o_err_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_line();
        do_reset();
        send_frame();
        drive_beat(1'b0, 1'b0, 24'($urandom));   // dropped, waiting for SOF
        for (int c = 0; c < 3; c++) drive_beat(c == 0, 1'b0, 24'($urandom));
        @(negedge clk);
        resetn = 1'b0; s_tvalid = 1'b1; s_tuser = 1'b0; s_tlast = 1'b0;
        @(posedge clk); #1;
        n_total++; if (o_frame_count !== 16'd0 || o_err_count !== 16'd0 || s_tready !== 1'b0)
            $display("FAIL midreset got fc=%0d ec=%0d rdy=%0b required 0/0/0", o_frame_count, o_err_count, s_tready);
        else n_pass++;
        n_total++; if (o_x !== 11'd0 || o_y !== 10'd0 || o_pixel_valid !== 1'b0)
            $display("FAIL midreset_pos got x=%0d y=%0d pv=%0b required 0/0/0", o_x, o_y, o_pixel_valid);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1; s_tvalid = 1'b0;
        model_reset();
        // The discarded partial frame must not disturb the next one.
        send_frame();
        n_total++; if (o_frame_count !== 16'd1 || o_err_count !== 16'd0)
            $display("FAIL midreset_recover got fc=%0d ec=%0d required 1/0", o_frame_count, o_err_count);
        else n_pass++;
    endtask

    task automatic test_random();
        int sc, sr;
        bit u, l;
        do_reset();
        sc = 3; sr = 1;   // start mid-frame so the pre-SOF drop path is hit
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 4) == 0) idle_cycle();
            else begin
                u = (sc == 0 && sr == 0) || ($urandom_range(0, 59) == 0);
                l = (sc == H - 1) ^ ($urandom_range(0, 39) == 0);
                if (u) begin sc = 0; sr = 0; end
                drive_beat(u, l, 24'($urandom));
                if (l || sc == H - 1) begin sc = 0; sr = (sr + 1) % V; end
                else sc = sc + 1;
            end
            n_total++;
            if (o_pixel_valid !== m_pv || o_frame_done !== m_done || o_err_sof !== m_esof ||
                o_err_early_eol !== m_eearly || o_err_late_eol !== m_elate)
                $display("FAIL rand_pulses step%0d got %0b%0b%0b%0b%0b required %0b%0b%0b%0b%0b", i,
                         o_pixel_valid, o_frame_done, o_err_sof, o_err_early_eol, o_err_late_eol,
                         m_pv, m_done, m_esof, m_eearly, m_elate);
            else n_pass++;
            n_total++;
            if (o_x !== 11'(m_x) || o_y !== 10'(m_y) || o_pixel !== m_pix)
                $display("FAIL rand_pixel step%0d got %0d/%0d/%0h required %0d/%0d/%0h", i, o_x, o_y, o_pixel, m_x, m_y, m_pix);
            else n_pass++;
            n_total++;
            if (o_frame_count !== m_fc || o_err_count !== m_ec || o_locked !== m_locked)
                $display("FAIL rand_stats step%0d got fc=%0d ec=%0d lk=%0b required %0d/%0d/%0b", i,
                         o_frame_count, o_err_count, o_locked, m_fc, m_ec, m_locked);
            else n_pass++;
        end
    endtask

`ifdef BACKPRESSURE_EN
    // Expected stall pattern: ready is the registered "low two LFSR bits not
    // both zero" of a free-running x^8+x^6+x^5+x^4+1 sequence from 8'hA5.
    logic [7:0] exp_lfsr;
    logic       exp_rdy;
    always @(posedge clk) begin
        if (!resetn) begin
            exp_lfsr <= 8'hA5;
            exp_rdy  <= 1'b0;
        end else begin
            exp_rdy  <= (exp_lfsr[1:0] != 2'b00);
            exp_lfsr <= {exp_lfsr[6:0], exp_lfsr[7] ^ exp_lfsr[5] ^ exp_lfsr[4] ^ exp_lfsr[3]};
        end
    end
    always @(negedge clk) begin
        n_total++;
        if (s_tready !== exp_rdy) $display("FAIL lfsr_ready got %0b required %0b", s_tready, exp_rdy);
        else n_pass++;
    end
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_clean_frames();
        test_drop_before_sof();
        test_early_eol();
        test_late_eol();
        test_mid_sof();
        test_reset_mid_line();
        test_random();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
